spi_exe_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared SPI execution unit. Up to N requesters (register interface, DMA and others) compete for one execution unit. The block grants the unit to exactly one requester at a time and issues a single-cycle start. It holds the grant until the unit reports completion or a watchdog expires. The granted one-hot vector is converted to a binary index by an instance of `onehot2nkb_encoder`; that index drives the execution unit's source-select mux.

---
 rtl/spi_exe_pkg.sv | 14 +
 rtl/spi_exe_arbiter_encoder.sv | 30 +++
 rtl/spi_exe_arbiter.sv | 100 ++++++++++
 tb/tb_spi_exe_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_exe_pkg.sv
// Shared types and defaults for the SPI execution-unit arbiter.
// Imported by the arbiter top.
package spi_exe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int ARB_N_DEF       = 4;
  localparam int ARB_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/spi_exe_arbiter_encoder.sv
// One-hot to binary index encoder.
// err is raised when the input is zero or has more than one bit set.
module onehot2nkb_encoder #(
  parameter int LEN = 4,
  localparam int W  = $clog2(LEN)
) (
  input  logic [LEN-1:0] onehot,
  output logic [W-1:0]   idx,
  output logic           err
);

  logic any_set;
  logic multi;

  // OR together indices of set bits and track one-hot violations
  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    multi   = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (onehot[i]) begin
        if (any_set) multi = 1'b1;
        any_set = 1'b1;
        idx     = idx | W'(i);
      end
    end
    err = !any_set || multi;
  end

endmodule

// File: rtl/spi_exe_arbiter.sv
// Round-robin arbiter and sequencer for the shared SPI execution unit.
// Grants one requester, pulses start, holds until done or watchdog.
module spi_exe_arbiter
  import spi_exe_pkg::*;
#(
  parameter int N       = ARB_N_DEF,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF,
  localparam int IDXW   = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req,
  input  logic            i_done,
  output logic [N-1:0]    o_grant,
  output logic [IDXW-1:0] o_grant_idx,
  output logic            o_grant_vld,
  output logic            o_start,
  output logic            o_timeout,
  output logic            o_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  arb_state_t      state;
  logic [IDXW-1:0] last;
  logic [CW-1:0]   cnt;
  logic            enc_err;
  logic            wd_hit;

  // Rotate so last+1 sits at bit 0, take lowest set bit, rotate back
  function automatic logic [N-1:0] rr_pick(
    input logic [N-1:0]    req,
    input logic [IDXW-1:0] lst
  );
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   sel;
    int             sh;
    sh  = (int'(lst) == N - 1) ? 0 : int'(lst) + 1;
    dbl = {req, req} >> sh;
    rot = dbl[N-1:0];
    sel = rot & (-rot);
    dbl = {sel, sel} << sh;
    return dbl[2*N-1:N];
  endfunction

  onehot2nkb_encoder #(
    .LEN(N)
  ) u_enc (
    .onehot(o_grant),
    .idx   (o_grant_idx),
    .err   (enc_err)
  );

  // done has priority, so the watchdog pulse is qualified by !i_done
  assign wd_hit    = (state == BUSY) && (cnt == CMAX);
  assign o_timeout = wd_hit && !i_done;
  assign o_err     = o_grant_vld && enc_err;

  // Sequencer: IDLE picks a winner, START pulses, BUSY waits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_grant     <= '0;
      o_grant_vld <= 1'b0;
      o_start     <= 1'b0;
      last        <= IDXW'(N - 1);
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|i_req) begin
            o_grant     <= rr_pick(i_req, last);
            o_grant_vld <= 1'b1;
            o_start     <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          o_start <= 1'b0;
          cnt     <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          if (i_done || wd_hit) begin
            last        <= o_grant_idx;
            o_grant     <= '0;
            o_grant_vld <= 1'b0;
            state       <= IDLE;
          end else if (cnt != CMAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_arbiter.sv
// Scoreboard bench for spi_exe_arbiter (N=4, TIMEOUT=8).
// Driver queues expected start/timeout events; a monitor checks them.
module tb_spi_exe_arbiter;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_req;
  logic       i_done;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_grant_vld;
  logic       o_start;
  logic       o_timeout;
  logic       o_err;

  typedef struct {
    logic       start;
    logic [3:0] grant;
    logic [1:0] idx;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  bit  err_seen = 0;

  spi_exe_arbiter #(
    .N(4),
    .TIMEOUT(8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_done     (i_done),
    .o_grant    (o_grant),
    .o_grant_idx(o_grant_idx),
    .o_grant_vld(o_grant_vld),
    .o_start    (o_start),
    .o_timeout  (o_timeout),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic s, input logic [3:0] g,
                      input logic [1:0] ix);
    ev_t e;
    e.start = s;
    e.grant = g;
    e.idx   = ix;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every start/timeout pulse must match the next queued event
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_err) err_seen = 1'b1;
      if (o_start || o_timeout) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event start=%0b to=%0b grant=%b",
                   o_start, o_timeout, o_grant);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("event", {o_start, o_timeout, o_grant, o_grant_idx},
              {e.start, ~e.start, e.grant, e.idx});
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_done  = 1'b0;
    #1;
    chk("rst_grant", o_grant, 4'b0000);
    chk("rst_vld", o_grant_vld, 0);
    chk("rst_start", o_start, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // One full transaction entered from IDLE, released by done
  task automatic txn(input logic [3:0] req, input logic [3:0] eg,
                     input logic [1:0] ei, input int hold);
    i_req = req;
    push(1'b1, eg, ei);
    tick();
    chk("grant", o_grant, eg);
    chk("grant_vld", o_grant_vld, 1);
    tick();
    chk("start_low", o_start, 0);
    repeat (hold) tick();
    chk("held", o_grant, eg);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("released", o_grant_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0;
    i_req   = '0;
    i_done  = 1'b0;
    do_reset();
    chk("rst_timeout", o_timeout, 0);

    // reset priority then next in line
    txn(4'b1111, 4'b0001, 2'd0, 3);
    txn(4'b1111, 4'b0010, 2'd1, 2);

    // fairness and wrap with one IDLE cycle between grants
    do_reset();
    txn(4'b1001, 4'b0001, 2'd0, 1);
    txn(4'b1001, 4'b1000, 2'd3, 1);
    txn(4'b1001, 4'b0001, 2'd0, 1);
    txn(4'b1001, 4'b1000, 2'd3, 1);

    // request dropped while busy: grant holds, no second start
    i_req = 4'b0100;
    push(1'b1, 4'b0100, 2'd2);
    tick();
    chk("drop_grant", o_grant, 4'b0100);
    tick();
    i_req = 4'b0000;
    repeat (5) tick();
    chk("drop_held", o_grant, 4'b0100);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("drop_release", o_grant_vld, 0);

    // watchdog release
    do_reset();
    i_req = 4'b0010;
    push(1'b1, 4'b0010, 2'd1);
    tick();
    chk("to_grant", o_grant, 4'b0010);
    i_req = 4'b0000;
    push(1'b0, 4'b0010, 2'd1);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("to_pulse_%0d", j), o_timeout, (j == 8));
    end
    chk("to_vld_hold", o_grant_vld, 1);
    tick();
    chk("to_release", o_grant_vld, 0);
    chk("to_pulse_end", o_timeout, 0);
    i_req = 4'b1111;
    push(1'b1, 4'b0100, 2'd2);
    tick();
    chk("after_to_grant", o_grant, 4'b0100);

    // done coincident with the watchdog limit
    repeat (8) tick();
    i_done = 1'b1;
    i_req  = 4'b0000;
    #1;
    chk("coinc_no_timeout", o_timeout, 0);
    tick();
    i_done = 1'b0;
    chk("coinc_release", o_grant_vld, 0);

    // done in IDLE is ignored
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    chk("idle_done_vld", o_grant_vld, 0);
    chk("idle_done_grant", o_grant, 4'b0000);
    i_req = 4'b1111;
    push(1'b1, 4'b1000, 2'd3);
    tick();
    chk("idle_done_next", o_grant, 4'b1000);

    // async reset in the middle of BUSY
    tick();
    tick();
    #3;
    i_rst_n = 1'b0;
    i_req   = 4'b0000;
    #1;
    chk("arst_grant", o_grant, 4'b0000);
    chk("arst_vld", o_grant_vld, 0);
    chk("arst_start", o_start, 0);
    chk("arst_err", o_err, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    chk("arst_idle", o_grant_vld, 0);

    repeat (2) tick();
    chk("queue_empty", q.size(), 0);
    chk("err_never", err_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
